// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    HOLD    = 3'd2,
    MEASURE = 3'd3
  } state_t;

  // One Fibonacci step: XOR of tapped bits shifts in at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/f1_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a non-zero seed keeps it out of the all-zero state.
module f1_lfsr16
  import f1_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= lfsr_next(q);
  end

endmodule

// File: rtl/f1_light_seq.sv
// Start-light sequencer: light fill, random hold, lights-out, reaction timing
// and jump-start detection.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int unsigned       N_LIGHTS  = 8,
  parameter int unsigned       STEP_W    = 8,
  parameter int unsigned       HOLD_W    = 5,
  parameter int unsigned       RT_W      = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                tick,
  input  logic [STEP_W-1:0]   step_len,
  input  logic                response,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                lights_out,
  output logic                react_valid,
  output logic [RT_W-1:0]     react_time,
  output logic                jump_start
);

  state_t              state, state_nxt;
  logic [STEP_W-1:0]   step_cnt, step_cnt_nxt, step_eff;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt, hold_load;
  logic [RT_W-1:0]     rt_cnt, rt_cnt_nxt, react_time_nxt;
  logic [N_LIGHTS-1:0] data_nxt;
  logic                busy_nxt, lights_out_nxt, react_valid_nxt, jump_start_nxt;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                jump, step_last, hold_last, all_on;
  logic                unused_lfsr;

  f1_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[LFSR_W-1:HOLD_W];

  // step_len of 0 counts as 1; >= keeps a shrunk step_len from wrapping the counter
  assign step_eff  = (step_len == '0) ? STEP_W'(1) : step_len;
  assign step_last = (step_cnt >= step_eff - STEP_W'(1));
  assign hold_last = (hold_cnt == HOLD_W'(1));
  assign hold_load = (lfsr_q[HOLD_W-1:0] == '0) ? HOLD_W'(1) : lfsr_q[HOLD_W-1:0];
  assign all_on    = &data_out;
  assign jump      = response && ((state == FILL) || (state == HOLD));

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      data_out    <= '0;
      busy        <= 1'b0;
      lights_out  <= 1'b0;
      react_valid <= 1'b0;
      react_time  <= '0;
      jump_start  <= 1'b0;
      step_cnt    <= '0;
      hold_cnt    <= '0;
      rt_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      data_out    <= data_nxt;
      busy        <= busy_nxt;
      lights_out  <= lights_out_nxt;
      react_valid <= react_valid_nxt;
      react_time  <= react_time_nxt;
      jump_start  <= jump_start_nxt;
      step_cnt    <= step_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      rt_cnt      <= rt_cnt_nxt;
    end
  end

  // Next-state logic; a jump start wins over any step or lights-out
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = FILL;
      FILL: begin
        if (jump)                              state_nxt = IDLE;
        else if (tick && step_last && all_on)  state_nxt = HOLD;
      end
      HOLD: begin
        if (jump)                    state_nxt = IDLE;
        else if (tick && hold_last)  state_nxt = MEASURE;
      end
      MEASURE: if (response) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    data_nxt        = data_out;
    step_cnt_nxt    = step_cnt;
    hold_cnt_nxt    = hold_cnt;
    rt_cnt_nxt      = rt_cnt;
    react_time_nxt  = react_time;
    lights_out_nxt  = 1'b0;
    react_valid_nxt = 1'b0;
    jump_start_nxt  = 1'b0;
    busy_nxt        = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (trigger) begin
          data_nxt     = N_LIGHTS'(1);
          step_cnt_nxt = '0;
        end
      end
      FILL: begin
        if (jump) begin
          data_nxt       = '0;
          jump_start_nxt = 1'b1;
        end else if (tick) begin
          if (step_last) begin
            step_cnt_nxt = '0;
            if (all_on) hold_cnt_nxt = hold_load;
            else        data_nxt     = {data_out[N_LIGHTS-2:0], 1'b1};
          end else begin
            step_cnt_nxt = step_cnt + STEP_W'(1);
          end
        end
      end
      HOLD: begin
        if (jump) begin
          data_nxt       = '0;
          jump_start_nxt = 1'b1;
        end else if (tick) begin
          if (hold_last) begin
            data_nxt       = '0;
            lights_out_nxt = 1'b1;
            rt_cnt_nxt     = '0;
          end else begin
            hold_cnt_nxt = hold_cnt - HOLD_W'(1);
          end
        end
      end
      MEASURE: begin
        if (response) begin
          react_time_nxt  = rt_cnt;
          react_valid_nxt = 1'b1;
        end else if (!(&rt_cnt)) begin
          rt_cnt_nxt = rt_cnt + RT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_f1_light_seq.sv
// Bench for f1_light_seq: cycle model built from light counts and tick counts,
// plus scenario checks against fixed expectations.
module tb_f1_light_seq;

  localparam int N  = 8;
  localparam int SW = 8;
  localparam int HW = 5;
  localparam int RW = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int RT_MAX = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst, trigger, tick, response;
  logic [SW-1:0] step_len;
  logic [N-1:0]  data_out;
  logic          busy, lights_out, react_valid, jump_start;
  logic [RW-1:0] react_time;

  int total = 0;
  int bad   = 0;

  f1_light_seq #(.N_LIGHTS(N), .STEP_W(SW), .HOLD_W(HW), .RT_W(RW), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .tick(tick), .step_len(step_len),
    .response(response), .data_out(data_out), .busy(busy), .lights_out(lights_out),
    .react_valid(react_valid), .react_time(react_time), .jump_start(jump_start)
  );

  always #5 clk = ~clk;

  // LFSR written from the polynomial x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  // Reference model: phase 0 idle, 1 fill, 2 hold, 3 measure; lit = number of lights on
  int ph, lit, tk, hl, rt_m, len, cyc;
  logic [15:0]   m_lfsr;
  logic          e_lo, e_rv, e_js;
  logic [RW-1:0] e_rt;
  logic [N-1:0]  e_data;
  logic [N+RW+3:0] obs, exp_v;

  always_comb e_data = N'((1 << lit) - 1);
  assign obs   = {data_out, busy, lights_out, react_valid, jump_start, react_time};
  assign exp_v = {e_data, (ph != 0), e_lo, e_rv, e_js, e_rt};

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      ph <= 0; lit <= 0; tk <= 0; hl <= 0; rt_m <= 0;
      e_lo <= 1'b0; e_rv <= 1'b0; e_js <= 1'b0; e_rt <= '0;
      m_lfsr <= SEED;
    end else begin
      m_lfsr <= lfsr_adv(m_lfsr, 1);
      e_lo <= 1'b0; e_rv <= 1'b0; e_js <= 1'b0;
      case (ph)
        0: if (trigger) begin ph <= 1; lit <= 1; tk <= 0; end
        1, 2: begin
          if (response) begin
            ph <= 0; lit <= 0; e_js <= 1'b1;
          end else if (tick && ph == 1) begin
            len = (step_len == 0) ? 1 : int'(step_len);
            if (tk + 1 < len) tk <= tk + 1;
            else begin
              tk <= 0;
              if (lit < N) lit <= lit + 1;
              else begin
                ph <= 2;
                hl <= (m_lfsr[HW-1:0] == 0) ? 1 : int'(m_lfsr[HW-1:0]);
              end
            end
          end else if (tick) begin
            if (hl <= 1) begin ph <= 3; lit <= 0; e_lo <= 1'b1; rt_m <= 0; end
            else hl <= hl - 1;
          end
        end
        default: begin
          if (response) begin ph <= 0; e_rv <= 1'b1; e_rt <= RW'(rt_m); end
          else if (rt_m < RT_MAX) rt_m <= rt_m + 1;
        end
      endcase
    end
  end

  task automatic clk_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; trigger = 1'b0; tick = 1'b0; response = 1'b0; step_len = 8'd1;
    clk_step(); clk_step();
    rst = 1'b0;
  endtask

  task automatic start_seq();
    trigger = 1'b1; clk_step(); trigger = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_state got=%h want=0", obs); end
    tick = 1'b1; step_len = 8'd1;
    start_seq();
    n = 0;
    while (data_out !== 8'hFF && n < 40) begin
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL model_reset got=%h want=%h", obs, exp_v); end
      clk_step(); n++;
    end
    clk_step();
    tick = 1'b0;
    clk_step();
    total++;
    if (busy !== 1'b1 || data_out !== 8'hFF)
      begin bad++; $display("FAIL in_hold got busy=%b data=%h want busy=1 data=ff", busy, data_out); end
    rst = 1'b1; clk_step(); clk_step(); rst = 1'b0;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_mid_hold got=%h want=0", obs); end
    tick = 1'b1;
    start_seq();
    total++;
    if (data_out !== 8'h01 || busy !== 1'b1)
      begin bad++; $display("FAIL restart got data=%h busy=%b want data=01 busy=1", data_out, busy); end
  endtask

  task automatic test_fill();
    int n, h_exp;
    logic [15:0] lv;
    do_reset();
    tick = 1'b1; step_len = 8'd1;
    start_seq();
    for (int i = 1; i <= N; i++) begin
      total++;
      if (data_out !== N'((1 << i) - 1))
        begin bad++; $display("FAIL fill_seq step=%0d got=%h want=%h", i, data_out, N'((1 << i) - 1)); end
      if (i < N) clk_step();
    end
    lv = lfsr_adv(SEED, cyc);
    h_exp = (lv[HW-1:0] == 0) ? 1 : int'(lv[HW-1:0]);
    n = 0;
    while (data_out === 8'hFF && n < 100) begin
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL model_fill got=%h want=%h", obs, exp_v); end
      clk_step(); n++;
    end
    total++;
    if (n != h_exp + 1) begin bad++; $display("FAIL hold_len got=%0d want=%0d", n, h_exp + 1); end
    total++;
    if (lights_out !== 1'b1 || data_out !== '0)
      begin bad++; $display("FAIL lights_out_pulse got lo=%b data=%h want lo=1 data=00", lights_out, data_out); end
    clk_step();
    total++;
    if (lights_out !== 1'b0) begin bad++; $display("FAIL lights_out_width got=%b want=0", lights_out); end
    response = 1'b1; clk_step(); response = 1'b0;
  endtask

  task automatic test_step_len(input logic [SW-1:0] sl, input bit alt, input int spacing);
    int n, last;
    logic [N-1:0] prev;
    do_reset();
    step_len = sl; tick = 1'b1;
    start_seq();
    prev = '0; last = 0; n = 0;
    while (data_out !== 8'hFF && n < 300) begin
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL model_step got=%h want=%h", obs, exp_v); end
      if (data_out !== prev) begin
        if (prev != 0) begin
          total++;
          if (cyc - last != spacing)
            begin bad++; $display("FAIL step_spacing len=%0d got=%0d want=%0d", sl, cyc - last, spacing); end
        end
        last = cyc; prev = data_out;
      end
      if (alt) tick = ~tick;
      clk_step(); n++;
    end
    total++;
    if (data_out !== 8'hFF || cyc - last != spacing)
      begin bad++; $display("FAIL step_last got data=%h gap=%0d want data=ff gap=%0d", data_out, cyc - last, spacing); end
    response = 1'b1; clk_step(); response = 1'b0; clk_step();
  endtask

  task automatic wait_lights_out(input string tag);
    int n;
    n = 0;
    while (lights_out !== 1'b1 && n < 300) begin
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL model_%s got=%h want=%h", tag, obs, exp_v); end
      clk_step(); n++;
    end
    total++;
    if (lights_out !== 1'b1) begin bad++; $display("FAIL timeout_%s got lo=%b want 1", tag, lights_out); end
  endtask

  task automatic test_react();
    do_reset();
    tick = 1'b1; step_len = 8'd1;
    start_seq();
    wait_lights_out("react");
    for (int i = 0; i < 5; i++) clk_step();
    response = 1'b1; clk_step(); response = 1'b0;
    total++;
    if (react_valid !== 1'b1 || react_time !== 16'd5 || busy !== 1'b0)
      begin bad++; $display("FAIL react_5 got rv=%b rt=%0d busy=%b want rv=1 rt=5 busy=0", react_valid, react_time, busy); end
    clk_step();
    total++;
    if (react_valid !== 1'b0 || react_time !== 16'd5)
      begin bad++; $display("FAIL react_hold got rv=%b rt=%0d want rv=0 rt=5", react_valid, react_time); end
    start_seq();
    wait_lights_out("react0");
    response = 1'b1; clk_step(); response = 1'b0;
    total++;
    if (react_valid !== 1'b1 || react_time !== 16'd0)
      begin bad++; $display("FAIL react_zero got rv=%b rt=%0d want rv=1 rt=0", react_valid, react_time); end
    clk_step();
  endtask

  task automatic test_jump();
    int n;
    do_reset();
    tick = 1'b1; step_len = 8'd1;
    start_seq();
    wait_lights_out("jump_pre");
    for (int i = 0; i < 3; i++) clk_step();
    response = 1'b1; clk_step(); response = 1'b0; clk_step();
    start_seq();
    n = 0;
    while (data_out !== 8'h07 && n < 20) begin clk_step(); n++; end
    response = 1'b1; clk_step(); response = 1'b0;
    total++;
    if (data_out !== '0 || jump_start !== 1'b1 || react_valid !== 1'b0 || react_time !== 16'd3 || busy !== 1'b0)
      begin bad++; $display("FAIL jump_fill got data=%h js=%b rv=%b rt=%0d busy=%b want 00 1 0 3 0",
                            data_out, jump_start, react_valid, react_time, busy); end
    clk_step();
    total++;
    if (jump_start !== 1'b0) begin bad++; $display("FAIL jump_width got=%b want=0", jump_start); end
    start_seq();
    n = 0;
    while (!(ph == 2 && hl == 1) && n < 100) begin clk_step(); n++; end
    total++;
    if (!(ph == 2 && hl == 1)) begin bad++; $display("FAIL timeout_hold_final got ph=%0d hl=%0d want 2 1", ph, hl); end
    response = 1'b1; clk_step(); response = 1'b0;
    total++;
    if (jump_start !== 1'b1 || lights_out !== 1'b0 || data_out !== '0 || react_time !== 16'd3)
      begin bad++; $display("FAIL jump_hold_final got js=%b lo=%b data=%h rt=%0d want 1 0 00 3",
                            jump_start, lights_out, data_out, react_time); end
    clk_step();
  endtask

  task automatic test_misc();
    logic [N-1:0] frozen;
    do_reset();
    tick = 1'b1; step_len = 8'd1;
    start_seq();
    clk_step(); clk_step();
    trigger = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clk_step();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL trigger_busy got=%h want=%h", obs, exp_v); end
    end
    trigger = 1'b0;
    tick = 1'b0;
    frozen = data_out;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      total++;
      if (data_out !== frozen || busy !== 1'b1)
        begin bad++; $display("FAIL tick_freeze got=%h want=%h", data_out, frozen); end
    end
    tick = 1'b1;
    wait_lights_out("sat");
    for (int i = 0; i < RT_MAX + 1 + 10; i++) begin
      clk_step();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL model_sat got=%h want=%h", obs, exp_v); end
    end
    response = 1'b1; clk_step(); response = 1'b0;
    total++;
    if (react_valid !== 1'b1 || react_time !== 16'hFFFF)
      begin bad++; $display("FAIL rt_saturate got rv=%b rt=%h want rv=1 rt=ffff", react_valid, react_time); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      trigger  = ($urandom % 8) == 0;
      tick     = $urandom % 2;
      step_len = SW'($urandom % 4);
      response = ($urandom % 40) == 0;
      clk_step();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL model_random cyc=%0d got=%h want=%h", i, obs, exp_v); end
    end
    response = 1'b0; trigger = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_step_len(8'd3, 1'b1, 6);
    test_step_len(8'd0, 1'b0, 1);
    test_step_len(8'd1, 1'b1, 2);
    test_react();
    test_jump();
    test_misc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
